// File: rtl/mem_req_arbiter_if.sv
// Bus bundle between the cache channels, the arbiter and the memory port.
// master = arbiter side, slave = environment (caches + memory controller).
interface mem_req_arbiter_if #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 26,
  parameter int DATA_W   = 512,
  parameter int TAG_IN_W = 8
);
  localparam int BYTEEN_W  = DATA_W / 8;
  localparam int CH_W      = $clog2(NUM_CH);
  localparam int TAG_OUT_W = TAG_IN_W + CH_W;

  logic [NUM_CH-1:0]                 ch_req_valid_i;
  logic [NUM_CH-1:0]                 ch_req_rw_i;
  logic [NUM_CH-1:0][BYTEEN_W-1:0]   ch_req_byteen_i;
  logic [NUM_CH-1:0][ADDR_W-1:0]     ch_req_addr_i;
  logic [NUM_CH-1:0][DATA_W-1:0]     ch_req_data_i;
  logic [NUM_CH-1:0][TAG_IN_W-1:0]   ch_req_tag_i;
  logic [NUM_CH-1:0]                 ch_req_ready_o;

  logic [NUM_CH-1:0]                 ch_rsp_valid_o;
  logic [DATA_W-1:0]                 ch_rsp_data_o;
  logic [TAG_IN_W-1:0]               ch_rsp_tag_o;
  logic [NUM_CH-1:0]                 ch_rsp_ready_i;

  logic                              mem_req_valid_o;
  logic                              mem_req_rw_o;
  logic [BYTEEN_W-1:0]               mem_req_byteen_o;
  logic [ADDR_W-1:0]                 mem_req_addr_o;
  logic [DATA_W-1:0]                 mem_req_data_o;
  logic [TAG_OUT_W-1:0]              mem_req_tag_o;
  logic                              mem_req_ready_i;

  logic                              mem_rsp_valid_i;
  logic [DATA_W-1:0]                 mem_rsp_data_i;
  logic [TAG_OUT_W-1:0]              mem_rsp_tag_i;
  logic                              mem_rsp_ready_o;

  modport master (
    input  ch_req_valid_i, ch_req_rw_i, ch_req_byteen_i, ch_req_addr_i,
           ch_req_data_i, ch_req_tag_i, ch_rsp_ready_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_tag_i,
    output ch_req_ready_o, ch_rsp_valid_o, ch_rsp_data_o, ch_rsp_tag_o,
           mem_req_valid_o, mem_req_rw_o, mem_req_byteen_o, mem_req_addr_o,
           mem_req_data_o, mem_req_tag_o, mem_rsp_ready_o
  );

  modport slave (
    output ch_req_valid_i, ch_req_rw_i, ch_req_byteen_i, ch_req_addr_i,
           ch_req_data_i, ch_req_tag_i, ch_rsp_ready_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_tag_i,
    input  ch_req_ready_o, ch_rsp_valid_o, ch_rsp_data_o, ch_rsp_tag_o,
           mem_req_valid_o, mem_req_rw_o, mem_req_byteen_o, mem_req_addr_o,
           mem_req_data_o, mem_req_tag_o, mem_rsp_ready_o
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// N-channel round-robin memory request arbiter with one output register,
// tag-indexed response routing and per-channel outstanding-read caps.

module mem_req_arbiter_pend #(
  parameter int MAX_PEND = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic dec,
  output logic full
);
  localparam int CW = $clog2(MAX_PEND + 1);
  logic [CW-1:0] cnt;

  // simultaneous inc/dec cancel; count saturates at both ends
  always_ff @(posedge clk_i) begin
    if (rst_i)                                cnt <= '0;
    else if (inc && !dec && !full)            cnt <= cnt + CW'(1);
    else if (dec && !inc && cnt != '0)        cnt <= cnt - CW'(1);
  end

  assign full = (cnt == CW'(MAX_PEND));
endmodule

module mem_req_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 26,
  parameter int DATA_W   = 512,
  parameter int TAG_IN_W = 8,
  parameter int MAX_PEND = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_req_arbiter_if.master  bus,
  output logic [NUM_CH-1:0]  pend_full_o,
  output logic               err_o
);
  localparam int CH_W      = $clog2(NUM_CH);
  localparam int TAG_OUT_W = TAG_IN_W + CH_W;

  logic [CH_W-1:0]   last_grant, gidx, cidx, rsp_idx;
  logic [NUM_CH-1:0] elig, grant, full, rd_acc, rsp_hs;
  logic              found, load, xfer, rsp_in_range;
  int                cand;

  assign elig = bus.ch_req_valid_i & (bus.ch_req_rw_i | ~full);

  // first eligible channel after the last winner
  always_comb begin
    grant = '0;
    gidx  = last_grant;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = (int'(last_grant) + k) % NUM_CH;
      cidx = CH_W'(cand);
      if (!found && elig[cidx]) begin
        grant[cidx] = 1'b1;
        gidx        = cidx;
        found       = 1'b1;
      end
    end
  end

  assign load               = !bus.mem_req_valid_o || bus.mem_req_ready_i;
  assign xfer               = found && load;
  assign bus.ch_req_ready_o = grant & {NUM_CH{load}};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.mem_req_valid_o <= 1'b0;
      last_grant          <= CH_W'(NUM_CH - 1);
      err_o               <= 1'b0;
    end else begin
      if (xfer) begin
        bus.mem_req_valid_o <= 1'b1;
        last_grant          <= gidx;
      end else if (bus.mem_req_ready_i) begin
        bus.mem_req_valid_o <= 1'b0;
      end
      if (bus.mem_rsp_valid_i && !rsp_in_range) err_o <= 1'b1;
    end
  end

  // payload is qualified by mem_req_valid_o, so it carries no reset
  always_ff @(posedge clk_i) begin
    if (xfer) begin
      bus.mem_req_rw_o     <= bus.ch_req_rw_i[gidx];
      bus.mem_req_byteen_o <= bus.ch_req_byteen_i[gidx];
      bus.mem_req_addr_o   <= bus.ch_req_addr_i[gidx];
      bus.mem_req_data_o   <= bus.ch_req_data_i[gidx];
      bus.mem_req_tag_o    <= {bus.ch_req_tag_i[gidx], gidx};
    end
  end

  assign rsp_idx           = bus.mem_rsp_tag_i[CH_W-1:0];
  assign rsp_in_range      = int'(rsp_idx) < NUM_CH;
  assign bus.ch_rsp_data_o = bus.mem_rsp_data_i;
  assign bus.ch_rsp_tag_o  = bus.mem_rsp_tag_i[TAG_OUT_W-1:CH_W];

  // out-of-range index is swallowed: ready high, no channel sees it
  always_comb begin
    bus.ch_rsp_valid_o  = '0;
    bus.mem_rsp_ready_o = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rsp_in_range && rsp_idx == CH_W'(i)) begin
        bus.ch_rsp_valid_o[i] = bus.mem_rsp_valid_i;
        bus.mem_rsp_ready_o   = bus.ch_rsp_ready_i[i];
      end
    end
  end

  assign rd_acc = bus.ch_req_ready_o & ~bus.ch_req_rw_i;
  assign rsp_hs = bus.ch_rsp_valid_o & bus.ch_rsp_ready_i;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mem_req_arbiter_pend #(.MAX_PEND(MAX_PEND)) u_pend (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc   (rd_acc[i]),
      .dec   (rsp_hs[i]),
      .full  (full[i])
    );
  end

  assign pend_full_o = full;
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Parametrised N-channel memory-side arbiter that merges the memory ports of several data-cache instances onto one shared memory port. Requests are round-robin arbitrated into a single output pipeline register with the channel index appended to the tag. Responses are routed back by that index. Per-channel outstanding-read counters cap in-flight reads, a capability the single-channel cache wrapper lacks. The block sits between the per-cluster data caches and the memory controller.

## Interface
- NUM_CH, 2: number of cache channels; must be ≥2.
- ADDR_W, 26: memory line address width.
- DATA_W, 512: line data width; BYTEEN_W = DATA_W/8 (derived).
- TAG_IN_W, 8: per-channel memory tag width.
- MAX_PEND, 8: maximum outstanding reads per channel; must be ≥1.
- CH_W = $clog2(NUM_CH), derived; TAG_OUT_W = TAG_IN_W + CH_W, derived.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active high.
- ch_req_valid_i  in  NUM_CH  per-channel request valid.
- ch_req_rw_i  in  NUM_CH  1 = write.
- ch_req_byteen_i  in  NUM_CH*BYTEEN_W  byte enables; channel i at slice i.
- ch_req_addr_i  in  NUM_CH*ADDR_W  addresses.
- ch_req_data_i  in  NUM_CH*DATA_W  write data.
- ch_req_tag_i  in  NUM_CH*TAG_IN_W  tags.
- ch_req_ready_o  out  NUM_CH  per-channel accept.
- ch_rsp_valid_o  out  NUM_CH  response valid; one-hot or zero.
- ch_rsp_data_o  out  DATA_W  response data, broadcast to all channels.
- ch_rsp_tag_o  out  TAG_IN_W  restored channel tag, broadcast.
- ch_rsp_ready_i  in  NUM_CH  per-channel response ready.
- mem_req_valid_o, mem_req_rw_o  out  1  memory request.
- mem_req_byteen_o  out  BYTEEN_W.
- mem_req_addr_o  out  ADDR_W.
- mem_req_data_o  out  DATA_W.
- mem_req_tag_o  out  TAG_OUT_W  = {channel tag, channel index}.
- mem_req_ready_i  in  1.
- mem_rsp_valid_i  in  1.
- mem_rsp_data_i  in  DATA_W.
- mem_rsp_tag_i  in  TAG_OUT_W.
- mem_rsp_ready_o  out  1.
- pend_full_o  out  NUM_CH  channel i at MAX_PEND outstanding reads.
- err_o  out  1  sticky: response carried an out-of-range channel index.

## Operation
- Eligibility: channel i is eligible when ch_req_valid_i[i] is high and not (rw=0 and pend_cnt[i]==MAX_PEND). Writes are never blocked by the counter.
- Round-robin: search starts at (last_grant+1) mod NUM_CH; the first eligible channel gets the grant. The grant is combinational.
- Load condition: load = !mem_req_valid_o | mem_req_ready_i.
- ch_req_ready_o[i] = grant[i] & load. When a transfer happens, the output register captures the payload and the tag {tag_i, i[CH_W-1:0]}, and last_grant ← i.
- last_grant is unchanged when no transfer occurs. The grant may move between cycles while held requests are not accepted.
- Output register: a single entry with full throughput, so a new load is allowed in the same cycle the held entry drains. mem_req_valid_o clears when the entry drains with no new load.
- pend_cnt[i] (width $clog2(MAX_PEND+1)):
  - +1 on an accepted read from channel i.
  - −1 on a response handshake routed to channel i.
  - Both events in the same cycle: unchanged.
  - Never wraps. The eligibility rule prevents overflow; a response arriving at count 0 leaves the count at 0.
- pend_full_o[i] = (pend_cnt[i]==MAX_PEND).
- Response routing: idx = mem_rsp_tag_i[CH_W-1:0].
  - idx < NUM_CH: ch_rsp_valid_o[idx] = mem_rsp_valid_i; mem_rsp_ready_o = ch_rsp_ready_i[idx]; ch_rsp_tag_o = mem_rsp_tag_i[TAG_OUT_W-1:CH_W]. The response path is combinational.
  - idx ≥ NUM_CH (possible only when NUM_CH is not a power of 2): mem_rsp_ready_o = 1, the response is dropped with no ch_rsp_valid_o, and err_o is set on mem_rsp_valid_i.

## Timing
- Reset (rst_i sampled high at a clock edge):
  - mem_req_valid_o = 0.
  - All pend_cnt = 0, so pend_full_o = 0.
  - err_o = 0.
  - last_grant = NUM_CH−1, so channel 0 has first priority.
- Payload registers are not reset.
- Reset mid-operation discards the held request and clears the counters. Upstream must also be reset.
- Request latency: accept in cycle T → mem_req_valid_o in T+1. Sustained rate is 1 request/cycle while mem_req_ready_i stays high.
- mem_req_* is stable while mem_req_valid_o is high and mem_req_ready_i is low.
- Responses take 0 cycles. mem_rsp_ready_o depends combinationally on ch_rsp_ready_i.
- The counter update from a response is visible in eligibility the next cycle.
- err_o clears only on reset.

## Test plan
- Reset, then NUM_CH=2, all channels valid continuously with mem_req_ready_i=1 → grants alternate 0,1,0,1. The first mem_req_tag_o is {tag0,1'b0}, appearing one cycle after accept.
- NUM_CH=3, channel 0 valid only, mem_req_ready_i=0 for 4 cycles → one request held stable, ch_req_ready_o=0 for those cycles. Accepts resume on release at 1/cycle.
- MAX_PEND=2, channel 1 issues 3 reads with no responses → 2 accepted, pend_full_o[1]=1, the third is stalled. A write from channel 1 is still accepted. Return one response with tag {0x5,1} → ch_rsp_valid_o[1]=1, ch_rsp_tag_o=0x5, and the third read is accepted next cycle.
- Accepted read and returned response on channel 0 in the same cycle → pend_cnt[0] unchanged.
- NUM_CH=3, mem_rsp_tag_i low bits = 3 → mem_rsp_ready_o=1, no ch_rsp_valid_o, err_o=1 until reset.
- Assert rst_i with a request held and counts nonzero → next cycle mem_req_valid_o=0, pend_full_o=0, and channel 0 wins the next contest.
